host_cfg_table_loader: RTL and testbench
========================================

# host_cfg_table_loader

Consumes the 256-bit host configuration stream (valid/accept handshake) and decodes each word into writes against a per-instrument trigger table. The downstream trigger logic reads the table through a registered lookup port. The block sits directly downstream of the host configuration interface and upstream of the tick-to-trade decision stage.

## Interface
- DEPTH, 64, number of table entries; power of two, 2..256
- IDX_W, $clog2(DEPTH), lookup index width (derived)
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- in_config_valid  in  1  host word present
- in_config_data  in  256  host config word
- in_config_accept  out  1  block can take a word this cycle
- lookup_valid  in  1  lookup request
- lookup_idx  in  IDX_W  entry to read
- lookup_rvalid  out  1  lookup result valid, one cycle after the request
- lookup_hit  out  1  entry valid bit at lookup
- lookup_entry  out  128  {price_thr[63:0], min_vol[31:0], order_qty[31:0]}
- busy  out  1  CLEAR walk in progress
- err_count  out  16  saturating count of rejected words

## Operation
- Transfer occurs on a clock edge where in_config_valid && in_config_accept.
- Word fields:
  - opcode = [255:252]
  - index = [247:240]
  - payload = [127:0], mapped as price_thr = [127:64], min_vol = [63:32], order_qty = [31:0]
- Opcodes:
  - 0 NOP: no effect.
  - 1 WRITE: entry[index] <= payload, valid[index] <= 1.
  - 2 INVALIDATE: valid[index] <= 0; data is untouched.
  - 3 CLEAR_ALL: enters the CLEAR state.
  - 4..15 are illegal.
- Rejected words are illegal opcodes, WRITE/INVALIDATE with index >= DEPTH, and parity failures (see Configuration).
  - A rejected word is still accepted (consumed).
  - It changes no table state.
  - err_count increments and saturates at 16'hFFFF.
- FSM:
  - IDLE: in_config_accept = 1. A CLEAR_ALL transfer moves the FSM to CLEAR with the walk counter at 0.
  - CLEAR: in_config_accept = 0, busy = 1. One valid bit is cleared per cycle at index = walk counter. After clearing index DEPTH-1 the FSM returns to IDLE.
- Lookup reads data and valid bit read-before-write. A lookup sampled on the same edge as a WRITE to the same index returns the old contents.
- Lookups are serviced in every state, including CLEAR. Entries not yet walked still hit.

## Timing
- Reset values:
  - in_config_accept = 0
  - busy = 0
  - lookup_rvalid = 0
  - lookup_hit = 0
  - lookup_entry = 0
  - err_count = 0
  - all valid bits = 0
  - FSM = IDLE
- in_config_accept is registered. It rises on the first clock edge after reset deasserts.
- Table data storage is not reset.
- WRITE accepted at edge N: a lookup sampled at edge N+1 sees the new data. Its result is on lookup_rvalid/lookup_hit/lookup_entry after edge N+2.
- CLEAR_ALL accepted at edge N:
  - accept = 0 and busy = 1 after edge N.
  - index k is cleared at edge N+1+k.
  - accept = 1 and busy = 0 after edge N+DEPTH.
  - Back-to-back words therefore resume at edge N+DEPTH+1.
- Reset asserted mid-CLEAR: immediately IDLE, all valid bits = 0, accept = 0 until the first edge after release.
- err_count update is one cycle after the transfer edge.

## Configuration
- HOST_CFG_PARITY_EN defined:
  - in_config_data[248] must equal the XOR of bits [255:249] and [247:0] (even parity over the full word).
  - On mismatch the word is rejected (err_count++).
- Not defined: bit 248 is ignored and no parity logic is built.

## Structure
- Package host_cfg_pkg holds:
  - opcode enum: CFG_NOP, CFG_WRITE, CFG_INVAL, CFG_CLEAR
  - field bit-position localparams
  - cfg_entry_t packed struct (128 bits)
  - FSM state enum
- Sub-module cfg_table_ram: DEPTH x 128 storage, one synchronous write port and one registered read port. The valid bits live in the parent.

## Test plan
- Reset, then WRITE idx 5 with payload price 64'h1000, vol 32'd10, qty 32'd3; lookup idx 5 -> hit = 1 with that entry, two cycles after the write edge.
- WRITE idx 7, then INVALIDATE idx 7, then lookup 7 -> hit = 0. A fresh WRITE of the same idx before the lookup -> hit = 1 with the new data.
- CLEAR_ALL with DEPTH = 64 and all entries valid -> accept low for exactly 64 cycles. A lookup of idx 63 mid-walk -> hit = 1; after the walk -> hit = 0. A held next word transfers at edge N+65.
- Opcode 9, then WRITE idx 200 (DEPTH = 64) -> err_count = 2 and no table change. Force err_count to 16'hFFFF, send one more bad word -> stays 16'hFFFF.
- Same-edge WRITE idx 3 and lookup idx 3 -> old contents returned; a lookup on the next cycle -> new contents.
- With HOST_CFG_PARITY_EN: a WRITE with bit 248 flipped -> rejected and err_count = 1. Without the macro -> the same word is written.

Source files
------------

// File: rtl/host_cfg_pkg.sv
// Shared types and field positions for the host configuration table loader.
package host_cfg_pkg;

  localparam int unsigned CFG_WORD_W = 256;
  localparam int unsigned OP_HI      = 255;
  localparam int unsigned OP_LO      = 252;
  localparam int unsigned PAR_BIT    = 248;
  localparam int unsigned IDX_HI     = 247;
  localparam int unsigned IDX_LO     = 240;
  localparam int unsigned PAY_HI     = 127;
  localparam int unsigned PAY_LO     = 0;

  typedef enum logic [3:0] {
    CFG_NOP   = 4'd0,
    CFG_WRITE = 4'd1,
    CFG_INVAL = 4'd2,
    CFG_CLEAR = 4'd3
  } cfg_op_e;

  typedef struct packed {
    logic [63:0] price_thr;
    logic [31:0] min_vol;
    logic [31:0] order_qty;
  } cfg_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/cfg_table_ram.sv
// Trigger table payload storage: one synchronous write port, one registered
// read port with read-before-write behaviour on address collision.
module cfg_table_ram
  import host_cfg_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  cfg_entry_t       wdata,
  input  logic [IDX_W-1:0] raddr,
  output cfg_entry_t       rdata
);

  cfg_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/host_cfg_table_loader.sv
// Decodes host config words into trigger-table writes and serves lookups.
// Optional build macro HOST_CFG_PARITY_EN adds even-parity checking of each word.
module host_cfg_table_loader
  import host_cfg_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_config_valid,
  input  logic [255:0]     in_config_data,
  output logic             in_config_accept,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_rvalid,
  output logic             lookup_hit,
  output logic [127:0]     lookup_entry,
  output logic             busy,
  output logic [15:0]      err_count
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  cfg_state_e       state;
  logic [IDX_W-1:0] walk;
  logic [DEPTH-1:0] valid_bits;

  logic             xfer;
  logic [3:0]       op;
  logic [7:0]       idx;
  logic [IDX_W-1:0] idx_w;
  cfg_entry_t       payload;
  logic             legal_op;
  logic             needs_idx;
  logic             idx_ok;
  logic             par_ok;
  logic             reject;
  logic             do_write;
  logic             do_inval;
  logic             do_clear;
  logic             unused_bits;

  assign xfer    = in_config_valid && in_config_accept;
  assign op      = in_config_data[OP_HI:OP_LO];
  assign idx     = in_config_data[IDX_HI:IDX_LO];
  assign idx_w   = idx[IDX_W-1:0];
  assign payload = cfg_entry_t'(in_config_data[PAY_HI:PAY_LO]);

`ifdef HOST_CFG_PARITY_EN
  // Bit 248 is chosen by the host so the whole word XORs to zero.
  assign par_ok      = ~(^in_config_data);
  assign unused_bits = 1'b0;
`else
  assign par_ok      = 1'b1;
  assign unused_bits = ^{in_config_data[251:PAR_BIT], in_config_data[239:128]};
`endif

  assign legal_op  = op inside {CFG_NOP, CFG_WRITE, CFG_INVAL, CFG_CLEAR};
  assign needs_idx = (op == CFG_WRITE) || (op == CFG_INVAL);
  assign idx_ok    = int'(idx) < DEPTH;
  assign reject    = !par_ok || !legal_op || (needs_idx && !idx_ok);
  assign do_write  = xfer && !reject && (op == CFG_WRITE);
  assign do_inval  = xfer && !reject && (op == CFG_INVAL);
  assign do_clear  = xfer && !reject && (op == CFG_CLEAR);

  // Control FSM and valid bits; accept/busy are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      walk             <= '0;
      in_config_accept <= 1'b0;
      busy             <= 1'b0;
      valid_bits       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_config_accept <= 1'b1;
          if (do_write) begin
            valid_bits[idx_w] <= 1'b1;
          end else if (do_inval) begin
            valid_bits[idx_w] <= 1'b0;
          end else if (do_clear) begin
            state            <= ST_CLEAR;
            walk             <= '0;
            in_config_accept <= 1'b0;
            busy             <= 1'b1;
          end
        end
        ST_CLEAR: begin
          valid_bits[walk] <= 1'b0;
          walk             <= walk + IDX_W'(1);
          if (walk == IDX_W'(DEPTH - 1)) begin
            state            <= ST_IDLE;
            in_config_accept <= 1'b1;
            busy             <= 1'b0;
          end
        end
        default: begin
          state            <= ST_IDLE;
          in_config_accept <= 1'b0;
          busy             <= 1'b0;
        end
      endcase
    end
  end

  // Stage p0: reject flag captured at the transfer edge
  logic rej_p0;

  // Stage p1: error counter follows one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rej_p0    <= 1'b0;
      err_count <= '0;
    end else begin
      rej_p0 <= xfer && reject;
      if (rej_p0) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

  // Stage p0: table read and valid-bit sample, taken before any same-edge write lands
  logic       vld_p0;
  logic       hit_p0;
  cfg_entry_t rd_entry_p0;

  cfg_table_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (do_write),
    .waddr (idx_w),
    .wdata (payload),
    .raddr (lookup_idx),
    .rdata (rd_entry_p0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      hit_p0 <= 1'b0;
    end else begin
      vld_p0 <= lookup_valid;
      hit_p0 <= valid_bits[lookup_idx];
    end
  end

  // Stage p1: result registers, held between lookups
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lookup_rvalid <= 1'b0;
      lookup_hit    <= 1'b0;
      lookup_entry  <= '0;
    end else begin
      lookup_rvalid <= vld_p0;
      if (vld_p0) begin
        lookup_hit   <= hit_p0;
        lookup_entry <= rd_entry_p0;
      end
    end
  end

endmodule

// File: tb/tb_host_cfg_table_loader.sv
// Randomized self-checking bench for host_cfg_table_loader with a behavioural table model.
module tb_host_cfg_table_loader;

  localparam int DEPTH = 64;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_config_valid = 1'b0;
  logic [255:0]     in_config_data = '0;
  logic             in_config_accept;
  logic             lookup_valid = 1'b0;
  logic [IDX_W-1:0] lookup_idx = '0;
  logic             lookup_rvalid;
  logic             lookup_hit;
  logic [127:0]     lookup_entry;
  logic             busy;
  logic [15:0]      err_count;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;

  logic         exp_valid [DEPTH];
  logic         exp_known [DEPTH];
  logic [127:0] exp_data  [DEPTH];
  logic [15:0]  exp_err;
  logic         clear_active;
  int           clear_edge;

  host_cfg_table_loader #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_config_valid  (in_config_valid),
    .in_config_data   (in_config_data),
    .in_config_accept (in_config_accept),
    .lookup_valid     (lookup_valid),
    .lookup_idx       (lookup_idx),
    .lookup_rvalid    (lookup_rvalid),
    .lookup_hit       (lookup_hit),
    .lookup_entry     (lookup_entry),
    .busy             (busy),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Host word with random filler in unused fields and correct even parity in bit 248.
  function automatic logic [255:0] mk_word(input int op, input int idx, input logic [127:0] pay);
    logic [255:0] w;
    w = '0;
    w[255:252] = 4'(op);
    w[251:249] = 3'($urandom_range(0, 7));
    w[247:240] = 8'(idx);
    w[239:128] = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    w[127:0]   = pay;
    w[248]     = ^{w[255:249], w[247:0]};
    return w;
  endfunction

  function automatic void model_reset(input logic keep_data);
    for (int i = 0; i < DEPTH; i++) begin
      exp_valid[i] = 1'b0;
      if (!keep_data) begin
        exp_known[i] = 1'b0;
        exp_data[i]  = '0;
      end
    end
    exp_err      = 16'd0;
    clear_active = 1'b0;
    clear_edge   = 0;
  endfunction

  // During a CLEAR walk entry k is gone only for lookups sampled after edge clear_edge+1+k.
  function automatic logic model_hit(input int idx, input int sedge);
    if (clear_active && sedge > clear_edge + 1 + idx) return 1'b0;
    return exp_valid[idx];
  endfunction

  function automatic void model_apply(input logic [255:0] w);
    int   op;
    int   idx;
    logic bad;
    op  = int'(w[255:252]);
    idx = int'(w[247:240]);
    if (clear_active) begin
      for (int i = 0; i < DEPTH; i++) exp_valid[i] = 1'b0;
      clear_active = 1'b0;
    end
    bad = (op > 3) || ((op == 1 || op == 2) && idx >= DEPTH);
`ifdef HOST_CFG_PARITY_EN
    if (^w) bad = 1'b1;
`endif
    if (bad) begin
      if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      return;
    end
    if (op == 1) begin
      exp_valid[idx] = 1'b1;
      exp_data[idx]  = w[127:0];
      exp_known[idx] = 1'b1;
    end else if (op == 2) begin
      exp_valid[idx] = 1'b0;
    end else if (op == 3) begin
      clear_active = 1'b1;
      clear_edge   = edge_cnt;
    end
  endfunction

  // Presents a word, waits (bounded) for accept, returns #1 after the transfer edge.
  task automatic send_word(input logic [255:0] w);
    int n;
    n = 0;
    in_config_valid = 1'b1;
    in_config_data  = w;
    while (!in_config_accept && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_config_accept) begin
      checks++;
      failures++;
      $display("FAIL send_timeout accept=%0b required=1 within 300 cycles", in_config_accept);
      in_config_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_config_valid = 1'b0;
    model_apply(w);
  endtask

  task automatic do_lookup(input int idx, output logic rv, output logic h,
                           output logic [127:0] e, output int sedge);
    lookup_valid = 1'b1;
    lookup_idx   = IDX_W'(idx);
    @(posedge clk); #1;
    sedge        = edge_cnt;
    lookup_valid = 1'b0;
    @(posedge clk); #1;
    rv = lookup_rvalid;
    h  = lookup_hit;
    e  = lookup_entry;
  endtask

  task automatic test_reset();
    logic rv, h;
    logic [127:0] e;
    int s;
    model_reset(1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (in_config_accept !== 1'b0 || busy !== 1'b0 || lookup_rvalid !== 1'b0 ||
        lookup_hit !== 1'b0 || lookup_entry !== 128'd0 || err_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_values accept=%0b busy=%0b rvalid=%0b hit=%0b entry=%h err=%h required all zero",
               in_config_accept, busy, lookup_rvalid, lookup_hit, lookup_entry, err_count);
    end
    @(posedge clk); #1;
    checks++;
    if (in_config_accept !== 1'b1) begin
      failures++;
      $display("FAIL accept_after_release accept=%0b required=1", in_config_accept);
    end
    do_lookup(20, rv, h, e, s);
    checks++;
    if (rv !== 1'b1 || h !== 1'b0) begin
      failures++;
      $display("FAIL reset_lookup rvalid=%0b hit=%0b required rvalid=1 hit=0", rv, h);
    end
  endtask

  task automatic test_write_lookup();
    logic rv, h;
    logic [127:0] e;
    logic [127:0] pay;
    int s;
    pay = {64'h1000, 32'd10, 32'd3};
    send_word(mk_word(1, 5, pay));
    do_lookup(5, rv, h, e, s);
    checks++;
    if (rv !== 1'b1 || h !== 1'b1 || e !== pay) begin
      failures++;
      $display("FAIL write_lookup rvalid=%0b hit=%0b entry=%h required rvalid=1 hit=1 entry=%h",
               rv, h, e, pay);
    end
  endtask

  task automatic test_invalidate();
    logic rv, h;
    logic [127:0] e;
    logic [127:0] p1, p2;
    int s;
    p1 = rnd128();
    p2 = rnd128();
    send_word(mk_word(1, 7, p1));
    send_word(mk_word(2, 7, '0));
    do_lookup(7, rv, h, e, s);
    checks++;
    if (h !== 1'b0 || e !== p1) begin
      failures++;
      $display("FAIL invalidate hit=%0b entry=%h required hit=0 entry=%h", h, e, p1);
    end
    send_word(mk_word(2, 7, '0));
    send_word(mk_word(1, 7, p2));
    do_lookup(7, rv, h, e, s);
    checks++;
    if (h !== 1'b1 || e !== p2) begin
      failures++;
      $display("FAIL rewrite hit=%0b entry=%h required hit=1 entry=%h", h, e, p2);
    end
  endtask

  task automatic test_same_edge();
    logic [127:0] p_old, p_new, old_exp;
    logic old_hit;
    int s;
    p_old = rnd128();
    p_new = rnd128();
    send_word(mk_word(1, 3, p_old));
    in_config_valid = 1'b1;
    in_config_data  = mk_word(1, 3, p_new);
    lookup_valid    = 1'b1;
    lookup_idx      = IDX_W'(3);
    @(posedge clk); #1;
    s = edge_cnt;
    in_config_valid = 1'b0;
    old_hit = model_hit(3, s);
    old_exp = exp_data[3];
    model_apply(in_config_data);
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    checks++;
    if (lookup_rvalid !== 1'b1 || lookup_hit !== old_hit || lookup_entry !== old_exp) begin
      failures++;
      $display("FAIL same_edge_old rvalid=%0b hit=%0b entry=%h required rvalid=1 hit=%0b entry=%h",
               lookup_rvalid, lookup_hit, lookup_entry, old_hit, old_exp);
    end
    @(posedge clk); #1;
    checks++;
    if (lookup_hit !== 1'b1 || lookup_entry !== p_new) begin
      failures++;
      $display("FAIL same_edge_next hit=%0b entry=%h required hit=1 entry=%h",
               lookup_hit, lookup_entry, p_new);
    end
  endtask

  task automatic test_random();
    logic rv, h, eh;
    logic [127:0] e;
    int s, op, idx, li, r;
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      op = 1;
      else if (r < 65) op = 2;
      else if (r < 75) op = 0;
      else             op = int'($urandom_range(4, 15));
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 255))
                                        : int'($urandom_range(0, DEPTH - 1));
      send_word(mk_word(op, idx, rnd128()));
      if ($urandom_range(0, 1) == 1) begin
        li = int'($urandom_range(0, DEPTH - 1));
        do_lookup(li, rv, h, e, s);
        eh = model_hit(li, s);
        checks++;
        if (rv !== 1'b1 || h !== eh) begin
          failures++;
          $display("FAIL rand_hit idx=%0d rvalid=%0b hit=%0b required rvalid=1 hit=%0b", li, rv, h, eh);
        end
        if (exp_known[li]) begin
          checks++;
          if (e !== exp_data[li]) begin
            failures++;
            $display("FAIL rand_entry idx=%0d entry=%h required %h", li, e, exp_data[li]);
          end
        end
      end
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (err_count !== exp_err) begin
      failures++;
      $display("FAIL rand_err_count err=%h required %h", err_count, exp_err);
    end
  endtask

  task automatic test_errors();
    logic rv, h;
    logic [127:0] e, p8;
    logic [15:0] base;
    int s;
    p8 = rnd128();
    send_word(mk_word(1, 8, p8));
    repeat (2) @(posedge clk); #1;
    base = err_count;
    send_word(mk_word(9, 8, rnd128()));
    send_word(mk_word(1, 200, rnd128()));
    repeat (2) @(posedge clk); #1;
    checks++;
    if (err_count !== exp_err || exp_err - base != 16'd2) begin
      failures++;
      $display("FAIL err_two err=%h required %h (base %h + 2)", err_count, exp_err, base);
    end
    do_lookup(8, rv, h, e, s);
    checks++;
    if (h !== 1'b1 || e !== p8) begin
      failures++;
      $display("FAIL err_no_change hit=%0b entry=%h required hit=1 entry=%h", h, e, p8);
    end
  endtask

  task automatic test_parity();
    logic rv, h, eh;
    logic [127:0] e, p0, p1;
    logic [255:0] w;
    int s;
    p0 = rnd128();
    p1 = rnd128();
    send_word(mk_word(1, 12, p0));
    w = mk_word(1, 12, p1);
    w[248] = ~w[248];
    send_word(w);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (err_count !== exp_err) begin
      failures++;
      $display("FAIL parity_err err=%h required %h", err_count, exp_err);
    end
    do_lookup(12, rv, h, e, s);
    eh = model_hit(12, s);
    checks++;
    if (h !== eh || e !== exp_data[12]) begin
      failures++;
      $display("FAIL parity_entry hit=%0b entry=%h required hit=%0b entry=%h", h, e, eh, exp_data[12]);
    end
  endtask

  task automatic test_clear();
    logic rv, h, eh;
    logic [127:0] e, p10;
    logic [255:0] held;
    int n, low_cnt, n_edge, s;
    for (int i = 0; i < DEPTH; i++) send_word(mk_word(1, i, rnd128()));
    send_word(mk_word(3, 0, '0));
    n_edge = edge_cnt;
    checks++;
    if (in_config_accept !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_enter accept=%0b busy=%0b required accept=0 busy=1", in_config_accept, busy);
    end
    p10  = rnd128();
    held = mk_word(1, 10, p10);
    in_config_valid = 1'b1;
    in_config_data  = held;
    n = 0;
    low_cnt = 0;
    while (!in_config_accept && n < 300) begin
      low_cnt++;
      if (n == 1) begin
        lookup_valid = 1'b1;
        lookup_idx   = IDX_W'(63);
      end else if (n == 2) begin
        lookup_valid = 1'b0;
      end else if (n == 3) begin
        eh = model_hit(63, n_edge + 2);
        checks++;
        if (lookup_rvalid !== 1'b1 || lookup_hit !== eh || lookup_entry !== exp_data[63]) begin
          failures++;
          $display("FAIL clear_mid_63 rvalid=%0b hit=%0b entry=%h required rvalid=1 hit=%0b entry=%h",
                   lookup_rvalid, lookup_hit, lookup_entry, eh, exp_data[63]);
        end
        lookup_valid = 1'b1;
        lookup_idx   = IDX_W'(0);
      end else if (n == 4) begin
        lookup_valid = 1'b0;
      end else if (n == 5) begin
        eh = model_hit(0, n_edge + 4);
        checks++;
        if (lookup_hit !== eh) begin
          failures++;
          $display("FAIL clear_mid_0 hit=%0b required %0b", lookup_hit, eh);
        end
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (low_cnt != DEPTH || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_length low_cycles=%0d busy=%0b required low_cycles=%0d busy=0",
               low_cnt, busy, DEPTH);
    end
    @(posedge clk); #1;
    in_config_valid = 1'b0;
    checks++;
    if (edge_cnt != n_edge + DEPTH + 1) begin
      failures++;
      $display("FAIL clear_resume edge=%0d required %0d", edge_cnt, n_edge + DEPTH + 1);
    end
    model_apply(held);
    do_lookup(63, rv, h, e, s);
    checks++;
    if (h !== 1'b0) begin
      failures++;
      $display("FAIL clear_after_63 hit=%0b required 0", h);
    end
    do_lookup(10, rv, h, e, s);
    checks++;
    if (h !== 1'b1 || e !== p10) begin
      failures++;
      $display("FAIL clear_held_word hit=%0b entry=%h required hit=1 entry=%h", h, e, p10);
    end
  endtask

  task automatic test_saturation();
    while (exp_err != 16'hFFFF) send_word(mk_word(int'($urandom_range(4, 15)), 1, '0));
    repeat (2) @(posedge clk); #1;
    checks++;
    if (err_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL err_reach_max err=%h required FFFF", err_count);
    end
    send_word(mk_word(1, 250, '0));
    repeat (2) @(posedge clk); #1;
    checks++;
    if (err_count !== exp_err) begin
      failures++;
      $display("FAIL err_saturate err=%h required %h", err_count, exp_err);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic rv, h;
    logic [127:0] e;
    int s;
    send_word(mk_word(3, 0, '0));
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (in_config_accept !== 1'b0 || busy !== 1'b0 || err_count !== 16'd0 || lookup_entry !== 128'd0) begin
      failures++;
      $display("FAIL midclear_reset accept=%0b busy=%0b err=%h entry=%h required all zero",
               in_config_accept, busy, err_count, lookup_entry);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset(1'b1);
    checks++;
    if (in_config_accept !== 1'b0) begin
      failures++;
      $display("FAIL midclear_accept_hold accept=%0b required 0", in_config_accept);
    end
    @(posedge clk); #1;
    checks++;
    if (in_config_accept !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midclear_resume accept=%0b busy=%0b required accept=1 busy=0", in_config_accept, busy);
    end
    do_lookup(40, rv, h, e, s);
    checks++;
    if (h !== 1'b0 || e !== exp_data[40]) begin
      failures++;
      $display("FAIL midclear_lookup hit=%0b entry=%h required hit=0 entry=%h", h, e, exp_data[40]);
    end
  endtask

  initial begin
    test_reset();
    test_write_lookup();
    test_invalidate();
    test_same_edge();
    test_random();
    test_errors();
    test_parity();
    test_clear();
    test_saturation();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
